// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, addresses the zero-latency ROM and fills the IF/ID register.
// Optional feature macro: FETCH_PERF_CNT_EN adds the RedirectCnt/StallCnt performance counters.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        Halt,
  output logic [31:0] RomAddr,
  input  logic [31:0] RomInst,
  output logic [31:0] PC,
  output logic [31:0] IfIdInst,
  output logic [31:0] IfIdPC4,
  output logic        IfIdValid,
  output logic        Halted,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0] RedirectCnt,
  output logic [15:0] StallCnt,
`endif
  output logic        FetchFault
);

  localparam int unsigned XLEN      = 32;
  localparam int unsigned CNT_W     = 16;
  localparam logic [XLEN-1:0] ROM_LIMIT = XLEN'(ROM_WORDS * 4);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_nxt, inst_nxt, pc4_nxt;
  logic            valid_nxt, halted_nxt, fault_nxt;
  logic [XLEN-1:0] pc_plus4;
  logic            redirect_bad, advance_bad;
  logic            redirect_acc, stall_cnt_ev;

  // A fetch target must be word aligned and inside the ROM.
  function automatic logic target_bad(input logic [XLEN-1:0] t);
    return (t[1:0] != 2'b00) || (t >= ROM_LIMIT);
  endfunction

  assign RomAddr      = PC;
  assign pc_plus4     = PC + XLEN'(4);
  assign redirect_bad = target_bad(RedirectPC);
  assign advance_bad  = target_bad(pc_plus4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_BOOT;
      PC         <= RESET_PC;
      IfIdInst   <= '0;
      IfIdPC4    <= '0;
      IfIdValid  <= 1'b0;
      Halted     <= 1'b0;
      FetchFault <= 1'b0;
    end else begin
      state      <= state_nxt;
      PC         <= pc_nxt;
      IfIdInst   <= inst_nxt;
      IfIdPC4    <= pc4_nxt;
      IfIdValid  <= valid_nxt;
      Halted     <= halted_nxt;
      FetchFault <= fault_nxt;
    end
  end

  // Next-state and datapath; priority Halt > Redirect > Stall > advance.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = PC;
    inst_nxt     = IfIdInst;
    pc4_nxt      = IfIdPC4;
    valid_nxt    = IfIdValid;
    halted_nxt   = Halted;
    fault_nxt    = FetchFault;
    redirect_acc = 1'b0;
    stall_cnt_ev = 1'b0;

    unique case (state)
      ST_BOOT: begin
        valid_nxt = 1'b0;
        inst_nxt  = '0;
        if (Halt) begin
          state_nxt  = ST_HALT;
          halted_nxt = 1'b1;
        end else if (Redirect) begin
          if (redirect_bad) begin
            state_nxt = ST_FAULT;
            fault_nxt = 1'b1;
          end else begin
            state_nxt    = ST_RUN;
            pc_nxt       = RedirectPC;
            redirect_acc = 1'b1;
          end
        end else begin
          state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        if (Halt) begin
          state_nxt  = ST_HALT;
          halted_nxt = 1'b1;
          valid_nxt  = 1'b0;
          inst_nxt   = '0;
        end else if (Redirect) begin
          valid_nxt = 1'b0;
          inst_nxt  = '0;
          if (redirect_bad) begin
            state_nxt = ST_FAULT;
            fault_nxt = 1'b1;
          end else begin
            pc_nxt       = RedirectPC;
            redirect_acc = 1'b1;
          end
        end else if (Stall) begin
          stall_cnt_ev = 1'b1;
        end else if (advance_bad) begin
          state_nxt = ST_FAULT;
          fault_nxt = 1'b1;
          valid_nxt = 1'b0;
          inst_nxt  = '0;
        end else begin
          pc_nxt    = pc_plus4;
          inst_nxt  = RomInst;
          pc4_nxt   = pc_plus4;
          valid_nxt = 1'b1;
        end
      end

      ST_HALT, ST_FAULT: begin
        valid_nxt = 1'b0;
        inst_nxt  = '0;
      end

      default: state_nxt = ST_BOOT;
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] redirect_cnt_nxt, stall_cnt_nxt;

  // Saturating event counters; they only move on events seen in BOOT/RUN.
  always_comb begin
    redirect_cnt_nxt = RedirectCnt;
    stall_cnt_nxt    = StallCnt;
    if (redirect_acc && (RedirectCnt != {CNT_W{1'b1}}))
      redirect_cnt_nxt = RedirectCnt + CNT_W'(1);
    if (stall_cnt_ev && (StallCnt != {CNT_W{1'b1}}))
      stall_cnt_nxt = StallCnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      RedirectCnt <= '0;
      StallCnt    <= '0;
    end else begin
      RedirectCnt <= redirect_cnt_nxt;
      StallCnt    <= stall_cnt_nxt;
    end
  end
`else
  logic unused_cnt_ev;
  assign unused_cnt_ev = redirect_acc ^ stall_cnt_ev ^ (CNT_W == 0);
`endif

endmodule
